hazard_stall_unit: RTL

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// and a freeze FSM that holds the pipe while the CNN accelerator runs.
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT_W  = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic                  ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic                  PCSrcE,
  input  logic                  AccStartE,
  input  logic                  AccDone,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  AccBusy,
  output logic                  AccTimeout,
  output logic [CNT_W-1:0]      StallCount
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t                 state, state_nxt;
  logic [TIMEOUT_W-1:0]   wait_cnt;
  logic [TIMEOUT_W-1:0]   cnt_inc;
  logic                   timeout_hit;
  logic                   lw_stall;

  // wait_cnt is 0 on the first WAIT cycle; the limit is hit when the
  // incremented count reaches 2^TIMEOUT_W-2.
  assign cnt_inc     = wait_cnt + TIMEOUT_W'(1);
  assign timeout_hit = (cnt_inc == {{(TIMEOUT_W-1){1'b1}}, 1'b0});

  assign lw_stall = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (AccStartE && !PCSrcE) state_nxt = WAIT;
      WAIT:    if (AccDone) state_nxt = IDLE;
               else if (timeout_hit) state_nxt = ERR;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is forced low while reset is held, including the
  // combinational paths.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    AccBusy   = 1'b0;
    if (rst) begin
      if (RegWriteM && RD_M != '0 && RD_M == Rs1_E)      ForwardAE = 2'b10;
      else if (RegWriteW && RD_W != '0 && RD_W == Rs1_E) ForwardAE = 2'b01;
      if (RegWriteM && RD_M != '0 && RD_M == Rs2_E)      ForwardBE = 2'b10;
      else if (RegWriteW && RD_W != '0 && RD_W == Rs2_E) ForwardBE = 2'b01;
      if (state == WAIT) begin
        // Freeze F/D/E around the accelerator op and bubble into M.
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        FlushM  = 1'b1;
        AccBusy = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      AccTimeout <= 1'b0;
      StallCount <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? cnt_inc : '0;
      if (state_nxt == ERR) AccTimeout <= 1'b1;
      if (StallF && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule
